// File: rtl/gpr_pkg.sv
// Shared defaults and helpers for the general-purpose register file slice.
package gpr_pkg;

  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 5;
  localparam int GPR_PC_W   = 32;
  localparam int REG_ZERO   = 0;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/gpr_file_bypass_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by decode reservation,
// cleared by writeback, with per-read-port busy lookups.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int NRD    = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ResvEn,
  input  logic [ADDR_W-1:0]     ResvA,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     WA,
  input  logic [NRD*ADDR_W-1:0] RA,
  output logic [NRD-1:0]        Busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pending;
  logic             clr_en;
  logic             set_en;

  assign clr_en = WE && (WA != ADDR_W'(REG_ZERO));
  assign set_en = ResvEn && (ResvA != ADDR_W'(REG_ZERO));

  // Set is applied after clear so a new producer reserving the register a
  // retiring write just released keeps it pending.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[WA]    <= 1'b0;
      if (set_en) pending[ResvA] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic [ADDR_W-1:0] ra;
    assign ra      = RA[slice_lo(i, ADDR_W) +: ADDR_W];
    assign Busy[i] = pending[ra] && !(WE && (WA == ra))
                     && (ra != ADDR_W'(REG_ZERO));
  end

endmodule

// File: rtl/gpr_file_bypass.sv
// Register file with combinational read ports, write-to-read bypass,
// hazard scoreboard and a registered write-trace record.
module gpr_file_bypass
  import gpr_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int NRD    = 2,
  parameter int PC_W   = GPR_PC_W
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NRD*ADDR_W-1:0] RA,
  output logic [NRD*DATA_W-1:0] RD,
  output logic [NRD-1:0]        Busy,
  input  logic                  ResvEn,
  input  logic [ADDR_W-1:0]     ResvA,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     WA,
  input  logic [DATA_W-1:0]     WD,
  input  logic [PC_W-1:0]       WPC,
  output logic                  TrValid,
  output logic [PC_W-1:0]       TrPC,
  output logic [ADDR_W-1:0]     TrA,
  output logic [DATA_W-1:0]     TrD
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;

  assign wr_en = WE && (WA != ADDR_W'(REG_ZERO));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (wr_en) begin
      regs[WA] <= WD;
    end
  end

  // Register 0 is forced to zero on read so it never depends on array state.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    assign ra = RA[slice_lo(i, ADDR_W) +: ADDR_W];
    always_comb begin
      rd = regs[ra];
      if (ra == ADDR_W'(REG_ZERO)) rd = '0;
      else if (wr_en && (WA == ra)) rd = WD;
    end
    assign RD[slice_lo(i, DATA_W) +: DATA_W] = rd;
  end

  gpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_scoreboard (
    .Clk    (Clk),
    .Reset  (Reset),
    .ResvEn (ResvEn),
    .ResvA  (ResvA),
    .WE     (WE),
    .WA     (WA),
    .RA     (RA),
    .Busy   (Busy)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      TrValid <= 1'b0;
      TrPC    <= '0;
      TrA     <= '0;
      TrD     <= '0;
    end else begin
      TrValid <= wr_en;
      if (wr_en) begin
        TrPC <= WPC;
        TrA  <= WA;
        TrD  <= WD;
      end
    end
  end

endmodule

// File: tb/tb_gpr_file_bypass.sv
// Directed bench for gpr_file_bypass with four read ports.
module tb_gpr_file_bypass;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 4;
  localparam int PC_W   = 32;

  logic                  clk_sys;
  logic                  reset;
  logic [NRD*ADDR_W-1:0] ra;
  logic [NRD*DATA_W-1:0] rd;
  logic [NRD-1:0]        busy;
  logic                  resv_en;
  logic [ADDR_W-1:0]     resv_a;
  logic                  we;
  logic [ADDR_W-1:0]     wa;
  logic [DATA_W-1:0]     wd;
  logic [PC_W-1:0]       wpc;
  logic                  tr_valid;
  logic [PC_W-1:0]       tr_pc;
  logic [ADDR_W-1:0]     tr_a;
  logic [DATA_W-1:0]     tr_d;

  int checks   = 0;
  int failures = 0;

  gpr_file_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NRD    (NRD),
    .PC_W   (PC_W)
  ) dut (
    .Clk     (clk_sys),
    .Reset   (reset),
    .RA      (ra),
    .RD      (rd),
    .Busy    (busy),
    .ResvEn  (resv_en),
    .ResvA   (resv_a),
    .WE      (we),
    .WA      (wa),
    .WD      (wd),
    .WPC     (wpc),
    .TrValid (tr_valid),
    .TrPC    (tr_pc),
    .TrA     (tr_a),
    .TrD     (tr_d)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rd_of(input int p);
    return rd[p*DATA_W +: DATA_W];
  endfunction

  task automatic set_ra(input int p, input logic [ADDR_W-1:0] a);
    ra[p*ADDR_W +: ADDR_W] = a;
  endtask

  // Advance one edge; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    reset = 1'b1; ra = '0; resv_en = 1'b0; resv_a = '0;
    we = 1'b0; wa = '0; wd = '0; wpc = '0;
    step();
    step();
    reset = 1'b0;
    set_ra(0, 5'd5);
    #1;
    check("rst_rd0", 64'(rd_of(0)), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_trvalid", 64'(tr_valid), 64'h0);

    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; wpc = 32'h3000;
    #1;
    check("bypass_rd0", 64'(rd_of(0)), 64'hDEADBEEF);
    step();
    we = 1'b0;
    #1;
    check("tr_valid", 64'(tr_valid), 64'h1);
    check("tr_pc", 64'(tr_pc), 64'h3000);
    check("tr_a", 64'(tr_a), 64'h5);
    check("tr_d", 64'(tr_d), 64'hDEADBEEF);
    check("array_rd0", 64'(rd_of(0)), 64'hDEADBEEF);

    set_ra(0, 5'd0);
    we = 1'b1; wa = 5'd0; wd = 32'h1234; wpc = 32'h3004;
    #1;
    check("r0_rd", 64'(rd_of(0)), 64'h0);
    step();
    we = 1'b0;
    #1;
    check("r0_no_trace", 64'(tr_valid), 64'h0);
    check("tr_hold_a", 64'(tr_a), 64'h5);
    check("tr_hold_pc", 64'(tr_pc), 64'h3000);

    resv_en = 1'b1; resv_a = 5'd7; set_ra(1, 5'd7);
    #1;
    check("resv_not_yet", 64'(busy[1]), 64'h0);
    step();
    resv_en = 1'b0;
    #1;
    check("resv_busy1", 64'(busy[1]), 64'h1);
    we = 1'b1; wa = 5'd7; wd = 32'h55; wpc = 32'h3008;
    #1;
    check("retire_busy1", 64'(busy[1]), 64'h0);
    check("retire_rd1", 64'(rd_of(1)), 64'h55);
    step();
    we = 1'b0;
    #1;
    check("cleared_busy1", 64'(busy[1]), 64'h0);
    check("array_rd1", 64'(rd_of(1)), 64'h55);

    set_ra(2, 5'd9);
    resv_en = 1'b1; resv_a = 5'd9;
    we = 1'b1; wa = 5'd9; wd = 32'h11; wpc = 32'h300C;
    step();
    resv_en = 1'b0; we = 1'b0;
    #1;
    check("setwins_rd2", 64'(rd_of(2)), 64'h11);
    check("setwins_busy2", 64'(busy[2]), 64'h1);

    resv_en = 1'b1; resv_a = 5'd9;
    step();
    resv_en = 1'b0;
    #1;
    check("rereserve_busy2", 64'(busy[2]), 64'h1);

    we = 1'b1; wa = 5'd3; wd = 32'hAA; wpc = 32'h3010;
    resv_en = 1'b1; resv_a = 5'd4;
    set_ra(0, 5'd3); set_ra(3, 5'd4);
    step();
    we = 1'b0; resv_en = 1'b0;
    #1;
    check("pre_rst_rd0", 64'(rd_of(0)), 64'hAA);
    check("pre_rst_busy3", 64'(busy[3]), 64'h1);
    reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'hBB; wpc = 32'h4000;
    #1;
    check("rst_bypass_rd0", 64'(rd_of(0)), 64'hBB);
    step();
    reset = 1'b0; we = 1'b0;
    #1;
    check("post_rst_rd0", 64'(rd_of(0)), 64'h0);
    check("post_rst_busy3", 64'(busy[3]), 64'h0);
    check("post_rst_busy2", 64'(busy[2]), 64'h0);
    check("post_rst_trvalid", 64'(tr_valid), 64'h0);
    check("post_rst_trpc", 64'(tr_pc), 64'h0);
    check("post_rst_tra", 64'(tr_a), 64'h0);
    check("post_rst_trd", 64'(tr_d), 64'h0);

    for (int p = 0; p < NRD; p++) set_ra(p, 5'd12);
    we = 1'b1; wa = 5'd12; wd = 32'hCAFE; wpc = 32'h5000;
    #1;
    for (int p = 0; p < NRD; p++) check($sformatf("allport_byp%0d", p), 64'(rd_of(p)), 64'hCAFE);
    step();
    we = 1'b1; wa = 5'd20; wd = 32'h2020; wpc = 32'h100;
    #1;
    check("b2b_tr0_a", 64'(tr_a), 64'hC);
    for (int p = 0; p < NRD; p++) check($sformatf("allport_arr%0d", p), 64'(rd_of(p)), 64'hCAFE);
    step();
    wa = 5'd21; wd = 32'h2121; wpc = 32'h104;
    #1;
    check("b2b_tr1_valid", 64'(tr_valid), 64'h1);
    check("b2b_tr1_a", 64'(tr_a), 64'h14);
    check("b2b_tr1_pc", 64'(tr_pc), 64'h100);
    step();
    we = 1'b0;
    #1;
    check("b2b_tr2_valid", 64'(tr_valid), 64'h1);
    check("b2b_tr2_a", 64'(tr_a), 64'h15);
    check("b2b_tr2_d", 64'(tr_d), 64'h2121);
    step();
    check("b2b_tr_end", 64'(tr_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
